layer_ack_sequencer: RTL and testbench

Parametrised sequencer for one fully-connected layer of the neural network datapath. It counts per-input acknowledges from the multiply stage. After `N_IN` acks it raises a MAC-finalise request and holds it until the accumulator accepts it. It steps through `N_OUT` neurons and flags layer completion. It generalises the fixed two-ack, single-neuron layer counter with configurable depth and neuron count, a ready/valid handoff, restart, a selectable done mode and overrun detection.

---
 rtl/nn_seq_pkg.sv | 16 +
 rtl/wrap_counter.sv | 24 ++
 rtl/layer_ack_sequencer.sv | 105 ++++++++++
 tb/tb_layer_ack_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// rtl/nn_seq_pkg.sv - shared types and helpers for layer sequencers
package nn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    HANDOFF = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX counter with clear and terminal-count flag
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         last
);

  assign last = (q == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= last ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/layer_ack_sequencer.sv
// rtl/layer_ack_sequencer.sv - per-layer ack counter driving MAC finalise handoffs
module layer_ack_sequencer
  import nn_seq_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int N_OUT       = 4,
  parameter int STICKY_DONE = 1,
  parameter int IW          = idx_width(N_IN),
  parameter int OW          = idx_width(N_OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  input  logic          mac_ready,
  output logic          ack__mac,
  output logic [IW-1:0] in_idx,
  output logic [OW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  seq_state_t state, state_n;
  logic       start_ok, in_inc, out_inc, in_last, out_last, err_n;

  wrap_counter #(.MAX(N_IN), .W(IW)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .inc  (in_inc),
    .q    (in_idx),
    .last (in_last)
  );

  wrap_counter #(.MAX(N_OUT), .W(OW)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .inc  (out_inc),
    .q    (out_idx),
    .last (out_last)
  );

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    in_inc   = 1'b0;
    out_inc  = 1'b0;
    err_n    = err;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = ACCUM;
        end else if (ack) begin
          err_n = 1'b1;
        end
      end
      ACCUM: begin
        if (ack) begin
          in_inc = 1'b1;
          if (in_last) state_n = HANDOFF;
        end
      end
      HANDOFF: begin
        // Acks here belong to nobody: upstream must wait for the handoff to clear.
        if (ack) err_n = 1'b1;
        if (mac_ready) begin
          out_inc = 1'b1;
          state_n = out_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (STICKY_DONE != 0 && start) begin
          start_ok = 1'b1;
          state_n  = ACCUM;
        end else begin
          if (ack) err_n = 1'b1;
          if (STICKY_DONE == 0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start_ok) err_n = 1'b0;
  end

  // Outputs are registered decodes of the next state so nothing is combinational from inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack__mac <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      ack__mac <= (state_n == HANDOFF);
      busy     <= (state_n == ACCUM) || (state_n == HANDOFF);
      done     <= (state_n == DONE);
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_layer_ack_sequencer.sv
// tb/tb_layer_ack_sequencer.sv - directed scoreboard bench for layer_ack_sequencer
module tb_layer_ack_sequencer;

  logic clk;
  logic rst;

  logic a_start, a_ack, a_rdy, a_mac, a_busy, a_done, a_err;
  logic [0:0] a_in, a_out;
  logic b_start, b_ack, b_rdy, b_mac, b_busy, b_done, b_err;
  logic [1:0] b_in, b_out;
  logic c_start, c_ack, c_rdy, c_mac, c_busy, c_done, c_err;
  logic [0:0] c_in;
  logic [1:0] c_out;

  int checks = 0;
  int errors = 0;
  int hold;
  int exp_q[$];

  layer_ack_sequencer #(.N_IN(2), .N_OUT(1), .STICKY_DONE(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .ack(a_ack), .mac_ready(a_rdy),
    .ack__mac(a_mac), .in_idx(a_in), .out_idx(a_out), .busy(a_busy),
    .done(a_done), .err(a_err)
  );

  layer_ack_sequencer #(.N_IN(3), .N_OUT(4), .STICKY_DONE(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .ack(b_ack), .mac_ready(b_rdy),
    .ack__mac(b_mac), .in_idx(b_in), .out_idx(b_out), .busy(b_busy),
    .done(b_done), .err(b_err)
  );

  layer_ack_sequencer #(.N_IN(1), .N_OUT(3), .STICKY_DONE(0)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .ack(c_ack), .mac_ready(c_rdy),
    .ack__mac(c_mac), .in_idx(c_in), .out_idx(c_out), .busy(c_busy),
    .done(c_done), .err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a_pass;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    chk("a_busy_after_start", a_busy, 1);
    chk("a_done_clear", a_done, 0);
    a_ack = 1'b1;
    tick;
    chk("a_in_idx_1", a_in, 1);
    chk("a_mac_early", a_mac, 0);
    tick;
    a_ack = 1'b0;
    chk("a_mac_t3", a_mac, 1);
    chk("a_in_wrap", a_in, 0);
    tick;
    chk("a_mac_drop", a_mac, 0);
    chk("a_done_t4", a_done, 1);
    chk("a_busy_done", a_busy, 0);
    tick;
    chk("a_done_sticky", a_done, 1);
    chk("a_err", a_err, 0);
  endtask

  initial begin
    rst = 1'b1;
    {a_start, a_ack, a_rdy} = '0;
    {b_start, b_ack, b_rdy} = '0;
    {c_start, c_ack, c_rdy} = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_mac", b_mac, 0);
    chk("rst_in", b_in, 0);
    chk("rst_out", b_out, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_err", b_err, 0);

    // Two-ack single-neuron layer, accumulator always ready; then restart from DONE.
    a_rdy = 1'b1;
    run_a_pass();
    run_a_pass();

    // Three acks per neuron, four neurons, accumulator stalls each handoff.
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(n);
      b_ack = 1'b1;
      repeat (3) tick;
      b_ack = 1'b0;
      chk("b_mac_rise", b_mac, 1);
      chk("b_out_idx", b_out, exp_q.pop_front());
      hold = 0;
      while (b_mac === 1'b1 && hold < 20) begin
        hold++;
        if (hold == 5) b_rdy = 1'b1;
        tick;
      end
      b_rdy = 1'b0;
      chk("b_mac_hold", hold, 5);
      if (n < 3) begin
        chk("b_out_step", b_out, n + 1);
        chk("b_busy", b_busy, 1);
      end else begin
        chk("b_done", b_done, 1);
        chk("b_out_wrap", b_out, 0);
      end
      chk("b_err_clean", b_err, 0);
    end

    // Restart, start while busy, ack during handoff.
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_restart_done", b_done, 0);
    chk("b_restart_busy", b_busy, 1);
    b_ack = 1'b1;
    tick;
    b_ack = 1'b0;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_start_ignored_in", b_in, 1);
    chk("b_start_ignored_busy", b_busy, 1);
    chk("b_start_ignored_err", b_err, 0);
    b_ack = 1'b1;
    tick;
    tick;
    chk("b_handoff_mac", b_mac, 1);
    tick;
    b_ack = 1'b0;
    chk("b_overrun_in", b_in, 0);
    chk("b_overrun_err", b_err, 1);
    chk("b_overrun_mac", b_mac, 1);
    b_rdy = 1'b1;
    tick;
    b_rdy = 1'b0;
    chk("b_accept_out", b_out, 1);
    chk("b_err_sticky", b_err, 1);
    b_ack = 1'b1;
    repeat (3) tick;
    b_ack = 1'b0;
    b_rdy = 1'b1;
    tick;
    b_rdy = 1'b0;
    b_ack = 1'b1;
    tick;
    b_ack = 1'b0;
    chk("b_pre_rst_in", b_in, 1);
    chk("b_pre_rst_out", b_out, 2);

    // Mid-pass reset aborts everything.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("b_abort_in", b_in, 0);
    chk("b_abort_out", b_out, 0);
    chk("b_abort_busy", b_busy, 0);
    chk("b_abort_err", b_err, 0);
    hold = 0;
    repeat (6) begin
      tick;
      if (b_mac !== 1'b0 || b_done !== 1'b0) hold++;
    end
    chk("b_abort_quiet", hold, 0);
    b_ack = 1'b1;
    tick;
    b_ack = 1'b0;
    chk("b_idle_ack_err", b_err, 1);
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_start_clears_err", b_err, 0);

    // Single-ack neurons, pulsed done.
    c_rdy = 1'b1;
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(n);
      c_ack = 1'b1;
      tick;
      c_ack = 1'b0;
      chk("c_mac", c_mac, 1);
      chk("c_out_idx", c_out, exp_q.pop_front());
      tick;
      chk("c_mac_drop", c_mac, 0);
      if (n < 2) chk("c_out_step", c_out, n + 1);
      else chk("c_done_rise", c_done, 1);
    end
    hold = 0;
    while (c_done === 1'b1 && hold < 10) begin
      hold++;
      tick;
    end
    chk("c_done_pulse", hold, 1);
    chk("c_idle_busy", c_busy, 0);
    chk("c_idle_out", c_out, 0);
    chk("c_err", c_err, 0);
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    chk("c_restart_from_idle", c_busy, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
